multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter HALT_CODE, default 32'd10, the x17 value that makes ECALL halt.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port opcode  input  7  opcode of the instruction register.
REQ-005 SHALL have port bcond  input  1  branch-taken flag from the ALU.
REQ-006 SHALL have port x17_value  input  32  current register x17 contents.
REQ-007 SHALL have port mem_ready  input  1  memory handshake; access completes in the cycle it is high.
REQ-008 SHALL have outputs mem_read, mem_write, i_or_d (0=PC addr, 1=ALUOut addr), ir_write, reg_write, pc_write, each 1 bit.
REQ-009 SHALL have outputs alu_src_a (1 bit: 0=PC, 1=rs1), alu_src_b (2 bits: 0=rs2, 1=imm, 2=const 4), alu_op (2 bits: 0=add, 1=branch compare, 2=funct-decoded).
REQ-010 SHALL have outputs mem_to_reg (2 bits: 0=ALUOut, 1=MDR, 2=PC+4), pc_source (2 bits: 0=PC+4, 1=ALUOut, 2=ALU result), is_halted (1 bit), state (3 bits, debug).

Function
REQ-011 SHALL implement states IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to IF next cycle with all enables low.
REQ-012 IF: mem_read=1, i_or_d=0; ir_write=mem_ready; stay in IF while mem_ready=0, go to ID when 1.
REQ-013 ID: alu_src_a=0, alu_src_b=1, alu_op=0, so ALUOut captures PC+imm.
REQ-014 ID with opcode 1110011 (ECALL): x17_value==HALT_CODE -> HALT with no pc_write; else pc_write=1, pc_source=0, go to IF.
REQ-015 ID with unrecognised opcode: pc_write=1, pc_source=0, go to IF (NOP).
REQ-016 ID with any other recognised opcode (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111) SHALL go to EX.
REQ-017 EX R-type (0110011): alu_src_a=1, alu_src_b=0, alu_op=2, go to WB; I-type (0010011) same with alu_src_b=1.
REQ-018 EX load/store: alu_src_a=1, alu_src_b=1, alu_op=0, go to MEM.
REQ-019 EX branch: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write=1, pc_source=1 if bcond else 0, go to IF.
REQ-020 EX JAL: reg_write=1, mem_to_reg=2, pc_write=1, pc_source=1, go to IF.
REQ-021 EX JALR: alu_src_a=1, alu_src_b=1, alu_op=0, reg_write=1, mem_to_reg=2, pc_write=1, pc_source=2, go to IF.
REQ-022 MEM: i_or_d=1; load asserts mem_read, store asserts mem_write; stay in MEM while mem_ready=0.
REQ-023 MEM on mem_ready=1: load goes to WB; store asserts pc_write=1, pc_source=0 and goes to IF.
REQ-024 WB: reg_write=1, mem_to_reg=1 for load else 0, pc_write=1, pc_source=0, go to IF.
REQ-025 HALT: is_halted=1, every enable output 0; stays in HALT until reset.
REQ-026 Every output not named for a state SHALL be 0 in that state.
REQ-027 reg_write, pc_write, ir_write and mem_write SHALL each be high for at most one cycle per instruction.
REQ-028 With mem_ready tied high, cycles per instruction SHALL be: ECALL/NOP 2, branch/JAL/JALR 3, R/I-type/store 4, load 5.
REQ-029 Opcode SHALL be sampled only in ID, EX, MEM and WB; in IF it is ignored.

Reset
REQ-030 With reset=0 at a rising edge, state SHALL become IF, including from HALT or mid-MEM wait.
REQ-031 While reset=0, all enable outputs and is_halted SHALL be 0 regardless of state or inputs.
REQ-032 In the first cycle after reset returns to 1, the block SHALL be in IF with mem_read=1.

Verification
REQ-033 Reset, then opcode 0110011 with mem_ready=1 -> states IF,ID,EX,WB,IF; reg_write and pc_write (pc_source=0) high only in WB.
REQ-034 Load with mem_ready low for 2 cycles in MEM -> MEM held 3 cycles with mem_read=1, i_or_d=1; then WB with mem_to_reg=1; 7 cycles total.
REQ-035 Branch: bcond=1 -> EX has pc_write=1, pc_source=1; bcond=0 -> pc_source=0; 3 cycles each.
REQ-036 ECALL with x17_value=10 -> HALT after ID, is_halted=1 held 10+ cycles, no enables; ECALL with x17_value=5 -> IF after ID with pc_write=1.
REQ-037 Assert reset=0 during a store waiting in MEM -> next cycle IF, mem_write never asserted; reset=0 in HALT -> is_halted=0 and state IF.
REQ-038 Opcode 1111111 -> ID then IF with pc_write=1, pc_source=0, reg_write never asserted.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM: IF/ID/EX/MEM/WB/HALT sequencing with
// memory handshake stalls and ECALL-driven halt.
module multicycle_control #(
  parameter logic [31:0] HALT_CODE = 32'd10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        bcond,
  input  logic [31:0] x17_value,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        reg_write,
  output logic        pc_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  mem_to_reg,
  output logic [1:0]  pc_source,
  output logic        is_halted,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  state_e state_q, state_d;

  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr;
  logic is_ecall, is_known;

  logic       mr_c, mw_c, iod_c, irw_c, rw_c, pcw_c, asa_c, hlt_c;
  logic [1:0] asb_c, aop_c, m2r_c, pcs_c;

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign is_br    = (opcode == OP_BR);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_ecall = (opcode == OP_ECALL);
  assign is_known = is_r | is_i | is_ld | is_st
                  | is_br | is_jal | is_jalr;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF;
    mr_c  = 1'b0;
    mw_c  = 1'b0;
    iod_c = 1'b0;
    irw_c = 1'b0;
    rw_c  = 1'b0;
    pcw_c = 1'b0;
    asa_c = 1'b0;
    hlt_c = 1'b0;
    asb_c = 2'd0;
    aop_c = 2'd0;
    m2r_c = 2'd0;
    pcs_c = 2'd0;
    unique case (state_q)
      S_IF: begin
        mr_c    = 1'b1;
        irw_c   = mem_ready;
        state_d = mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        asb_c = 2'd1;
        if (is_ecall && x17_value == HALT_CODE) begin
          state_d = S_HALT;
        end else if (is_known) begin
          state_d = S_EX;
        end else begin
          pcw_c = 1'b1;
        end
      end
      S_EX: begin
        unique case (1'b1)
          is_r: begin
            asa_c   = 1'b1;
            aop_c   = 2'd2;
            state_d = S_WB;
          end
          is_i: begin
            asa_c   = 1'b1;
            asb_c   = 2'd1;
            aop_c   = 2'd2;
            state_d = S_WB;
          end
          is_ld, is_st: begin
            asa_c   = 1'b1;
            asb_c   = 2'd1;
            state_d = S_MEM;
          end
          is_br: begin
            asa_c = 1'b1;
            aop_c = 2'd1;
            pcw_c = 1'b1;
            pcs_c = bcond ? 2'd1 : 2'd0;
          end
          is_jal: begin
            rw_c  = 1'b1;
            m2r_c = 2'd2;
            pcw_c = 1'b1;
            pcs_c = 2'd1;
          end
          is_jalr: begin
            asa_c = 1'b1;
            asb_c = 2'd1;
            rw_c  = 1'b1;
            m2r_c = 2'd2;
            pcw_c = 1'b1;
            pcs_c = 2'd2;
          end
          default: pcw_c = 1'b1;
        endcase
      end
      S_MEM: begin
        iod_c = 1'b1;
        // store strobes only on the completing cycle: one write per instr
        if (is_st) begin
          mw_c    = mem_ready;
          pcw_c   = mem_ready;
          state_d = mem_ready ? S_IF : S_MEM;
        end else if (is_ld) begin
          mr_c    = 1'b1;
          state_d = mem_ready ? S_WB : S_MEM;
        end else begin
          pcw_c = 1'b1;
        end
      end
      S_WB: begin
        rw_c  = 1'b1;
        m2r_c = is_ld ? 2'd1 : 2'd0;
        pcw_c = 1'b1;
      end
      S_HALT: begin
        hlt_c   = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_IF;
    endcase
  end

  assign mem_read   = reset & mr_c;
  assign mem_write  = reset & mw_c;
  assign i_or_d     = reset & iod_c;
  assign ir_write   = reset & irw_c;
  assign reg_write  = reset & rw_c;
  assign pc_write   = reset & pcw_c;
  assign alu_src_a  = reset & asa_c;
  assign alu_src_b  = reset ? asb_c : 2'd0;
  assign alu_op     = reset ? aop_c : 2'd0;
  assign mem_to_reg = reset ? m2r_c : 2'd0;
  assign pc_source  = reset ? pcs_c : 2'd0;
  assign is_halted  = reset & hlt_c;
  assign state      = state_q;

endmodule
